// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: state encoding, widths,
// reset PC default and the word-offset scaling helper.
package fetch_pkg;

  localparam int INSN_W = 32;
  localparam int JIDX_W = 26;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_t;

  // Word offset to byte offset; the top two offset bits fall off modulo 2^32.
  function automatic logic [31:0] word_to_byte(input logic [31:0] word_off);
    return {word_off[29:0], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_npc.sv
// Combinational next-PC selection: jr > jump > taken branch > sequential.
// All sums wrap modulo 2^32.
module npc
  import fetch_pkg::*;
(
  input  logic [31:0]       pc,
  input  logic              br_taken,
  input  logic [31:0]       br_offset,
  input  logic              jump,
  input  logic [JIDX_W-1:0] jidx,
  input  logic              jr,
  input  logic [31:0]       jr_addr,
  output logic [31:0]       next_pc
);

  logic [31:0] pc_plus4;

  // Redirect priority mux
  always_comb begin
    pc_plus4 = pc + 32'd4;
    next_pc  = pc_plus4;
    if (jr) begin
      next_pc = jr_addr;
    end else if (jump) begin
      next_pc = {pc_plus4[31:28], jidx, 2'b00};
    end else if (br_taken) begin
      next_pc = pc_plus4 + word_to_byte(br_offset);
    end else begin
      next_pc = pc_plus4;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Two-state instruction fetch unit (FETCH/HOLD) with redirect on accept.
// Optional FETCH_ALIGN_CHECK_EN traps misaligned targets in a sticky fetch_err.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [31:0]       imem_addr,
  input  logic              imem_ack,
  input  logic [INSN_W-1:0] imem_rdata,
  output logic [INSN_W-1:0] cmd,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [31:0]       pc,
  input  logic              br_taken,
  input  logic [31:0]       br_offset,
  input  logic              jump,
  input  logic [JIDX_W-1:0] jidx,
  input  logic              jr,
  input  logic [31:0]       jr_addr,
  output logic              fetch_err
);

  state_t      state;
  state_t      state_nx;
  logic [31:0] raw_npc;
  logic [31:0] target;
  logic        misaligned;
  logic        accept;

  npc u_npc (
    .pc        (pc),
    .br_taken  (br_taken),
    .br_offset (br_offset),
    .jump      (jump),
    .jidx      (jidx),
    .jr        (jr),
    .jr_addr   (jr_addr),
    .next_pc   (raw_npc)
  );

`ifdef FETCH_ALIGN_CHECK_EN
  assign target     = raw_npc;
  assign misaligned = |raw_npc[1:0];

  // Sticky misaligned-target flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_err <= 1'b0;
    end else if (accept && misaligned) begin
      fetch_err <= 1'b1;
    end else begin
      fetch_err <= fetch_err;
    end
  end
`else
  logic unused_npc_low;
  assign unused_npc_low = ^raw_npc[1:0];
  assign target         = {raw_npc[31:2], 2'b00};
  assign misaligned     = 1'b0;
  assign fetch_err      = 1'b0;
`endif

  // The request is masked during reset so no fetch is issued while it is held.
  assign imem_req  = (state == FETCH) && !reset;
  assign imem_addr = pc;
  assign cmd_valid = (state == HOLD) && !fetch_err;
  assign accept    = (state == HOLD) && cmd_ready && !fetch_err;

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      FETCH: begin
        if (imem_ack) begin
          state_nx = HOLD;
        end else begin
          state_nx = FETCH;
        end
      end
      HOLD: begin
        if (accept && !misaligned) begin
          state_nx = FETCH;
        end else begin
          state_nx = HOLD;
        end
      end
      default: state_nx = FETCH;
    endcase
  end

  // State, instruction and PC registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      pc    <= RESET_PC;
      cmd   <= {INSN_W{1'b0}};
    end else begin
      state <= state_nx;
      if ((state == FETCH) && imem_ack) begin
        cmd <= imem_rdata;
      end
      if (accept && !misaligned) begin
        pc <= target;
      end
    end
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h0000_3000: the PC value loaded by reset.
REQ-002 SHALL provide port clk  input  1: the single clock; all state updates on its rising edge.
REQ-003 SHALL provide port reset  input  1: synchronous, active-high reset.
REQ-004 SHALL provide port imem_req  output  1: fetch request to instruction memory.
REQ-005 SHALL provide port imem_addr  output  32: byte address of the fetch, always equal to pc.
REQ-006 SHALL provide port imem_ack  input  1: imem_rdata valid this cycle.
REQ-007 SHALL provide port imem_rdata  input  32: fetched instruction word.
REQ-008 SHALL provide port cmd  output  32: instruction presented to the decoder.
REQ-009 SHALL provide port cmd_valid  output  1: cmd holds a fetched instruction.
REQ-010 SHALL provide port cmd_ready  input  1: the decoder/datapath consumes cmd this cycle.
REQ-011 SHALL provide port pc  output  32: address of the instruction being fetched or held.
REQ-012 SHALL provide redirect inputs, all sampled only in the accept cycle: br_taken (1), br_offset (32, sign-extended word offset), jump (1), jidx (26), jr (1), jr_addr (32).
REQ-013 SHALL provide port fetch_err  output  1: sticky misaligned-target flag (see Configuration).

Function
REQ-014 SHALL implement the states FETCH and HOLD; reset enters FETCH.
REQ-015 In FETCH: imem_req=1 and cmd_valid=0; on imem_ack, cmd<=imem_rdata and the next state is HOLD.
REQ-016 In HOLD: imem_req=0, cmd_valid=1, and cmd and pc are held stable while cmd_ready=0.
REQ-017 Accept = HOLD and cmd_ready; on accept, pc<=npc and the next state is FETCH.
REQ-018 npc priority: jr -> jr_addr; else jump -> {pc_plus4[31:28], jidx, 2'b00}; else br_taken -> pc_plus4 + (br_offset<<2); else pc_plus4.
REQ-019 pc_plus4 = pc+4 and all additions SHALL be modulo 2^32 (wrap silently, no flag).
REQ-020 Latency: an instruction with a zero-wait ack SHALL be fetched in one cycle and presented (cmd_valid=1) on the next cycle, giving a minimum of 2 cycles per instruction.
REQ-021 imem_ack outside FETCH SHALL be ignored; the number of imem wait cycles is unbounded.
REQ-022 Redirect inputs outside an accept cycle SHALL have no effect.

Reset
REQ-023 Asserting reset SHALL set pc=RESET_PC, cmd=0, cmd_valid=0, imem_req=0, fetch_err=0 and state=FETCH on the next edge.
REQ-024 An imem_ack coinciding with reset SHALL be discarded; the first request occurs in the first cycle after reset deasserts.

Configuration
REQ-025 With FETCH_ALIGN_CHECK_EN defined: an accept whose npc[1:0]!=0 SHALL set fetch_err, leave pc unchanged, stay in HOLD with cmd_valid=0, and remain there until reset.
REQ-026 Without FETCH_ALIGN_CHECK_EN: npc[1:0] SHALL be forced to 2'b00, and fetch_err SHALL be tied to 0.

Structure
REQ-027 A shared package fetch_pkg SHALL hold the state encoding, the RESET_PC default, the instruction width (32) and the jump index width (26).
REQ-028 The next-PC arithmetic SHALL be a combinational sub-module npc; the FSM, registers and handshake SHALL live in fetch_unit.

Verification
REQ-029 Reset, then release with a zero-wait ack returning 32'h0000_0021 -> imem_addr=32'h3000; next cycle cmd=32'h0000_0021, cmd_valid=1.
REQ-030 Sequential: three accepts with no redirect -> pc progresses 3000, 3004, 3008, 300C.
REQ-031 Stall: cmd_ready=0 for 5 cycles in HOLD -> cmd, pc and cmd_valid are constant and imem_req=0; the accept then fetches pc+4.
REQ-032 Priority: pc=3010 with jr=1 (jr_addr=3100), jump=1 (jidx=26'h0C80) and br_taken=1 simultaneously -> next pc=3100; jump-only -> 3200; branch-only with br_offset=-2 -> 300C.
REQ-033 Wrap and misalignment: pc=FFFF_FFFC with no redirect -> next pc=0; jr_addr=3102 with the macro defined -> fetch_err=1 and pc unchanged; without the macro -> pc=3100.
REQ-034 Reset mid-fetch: assert reset during a 3-cycle imem wait with ack on the reset cycle -> cmd=0, pc=3000, and a new request is issued after release.
